// File: rtl/dilithium_kg_unloader_pkg.sv
// Shared types and tables for the Dilithium keygen output unloader:
// segment tags, security-level encodings, segment lengths and segment order.
package dilithium_kg_unloader_pkg;

   typedef enum logic [2:0] {
      SEG_RHO,
      SEG_K,
      SEG_TR,
      SEG_S1,
      SEG_S2,
      SEG_T0,
      SEG_T1
   } seg_t;

   localparam logic [2:0]  LVL2      = 3'b010;
   localparam logic [2:0]  LVL3      = 3'b011;
   localparam logic [2:0]  LVL5      = 3'b101;
   localparam int unsigned CNT_W     = 10;
   localparam int unsigned SEG_IDX_W = 3;

   function automatic logic lvl_legal(input logic [2:0] lvl);
      return (lvl == LVL2) || (lvl == LVL3) || (lvl == LVL5);
   endfunction

   // Lengths are tabulated for 64-bit words and rescaled to the datapath width.
   function automatic logic [CNT_W-1:0] seg_words(input seg_t seg, input logic [2:0] lvl,
                                                  input int unsigned w);
      int unsigned base;
      base = 0;
      case (seg)
         SEG_RHO, SEG_K, SEG_TR: base = 4;
         SEG_S1:
            case (lvl)
               LVL2:    base = 48;
               LVL3:    base = 80;
               LVL5:    base = 84;
               default: base = 0;
            endcase
         SEG_S2:
            case (lvl)
               LVL2:    base = 48;
               LVL3:    base = 96;
               LVL5:    base = 96;
               default: base = 0;
            endcase
         SEG_T1:
            case (lvl)
               LVL2:    base = 160;
               LVL3:    base = 240;
               LVL5:    base = 320;
               default: base = 0;
            endcase
         SEG_T0:
            case (lvl)
               LVL2:    base = 208;
               LVL3:    base = 312;
               LVL5:    base = 416;
               default: base = 0;
            endcase
         default: base = 0;
      endcase
      return CNT_W'((base * 64) / w);
   endfunction

   function automatic seg_t seg_at(input logic hp, input logic [SEG_IDX_W-1:0] idx);
      seg_t s;
      s = SEG_RHO;
      if (hp) begin
         case (idx)
            3'd0:    s = SEG_RHO;
            3'd1:    s = SEG_K;
            3'd2:    s = SEG_S1;
            3'd3:    s = SEG_S2;
            3'd4:    s = SEG_T1;
            3'd5:    s = SEG_T0;
            default: s = SEG_TR;
         endcase
      end else begin
         case (idx)
            3'd0:    s = SEG_RHO;
            3'd1:    s = SEG_K;
            3'd2:    s = SEG_TR;
            3'd3:    s = SEG_S1;
            3'd4:    s = SEG_S2;
            3'd5:    s = SEG_T0;
            3'd6:    s = SEG_RHO;
            default: s = SEG_T1;
         endcase
      end
      return s;
   endfunction

   function automatic logic [SEG_IDX_W-1:0] last_seg_idx(input logic hp);
      return hp ? 3'd6 : 3'd7;
   endfunction

endpackage

// File: rtl/dilithium_kg_unloader_skid.sv
// Two-entry valid/ready buffer; input ready is registered from the next
// occupancy so the upstream never sees a combinational path from out_ready.
module kg_skid_buf #(
   parameter int unsigned DW = 69
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [1:0]    count
);

   logic [DW-1:0] mem [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    count_q;
   logic [1:0]    count_n;
   logic          push;
   logic          pop;

   assign out_valid = (count_q != 2'd0);
   assign out_data  = mem[rd_ptr];
   assign count     = count_q;

   always_comb begin
      push    = in_valid & in_ready;
      pop     = out_valid & out_ready;
      count_n = count_q;
      if (push && !pop) begin
         count_n = count_q + 2'd1;
      end else if (!push && pop) begin
         count_n = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0]   <= '0;
         mem[1]   <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count_q  <= 2'd0;
         in_ready <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count_q  <= count_n;
         in_ready <= (count_n != 2'd2);
      end
   end

endmodule

// File: rtl/dilithium_kg_unloader.sv
// Tags the keygen output word stream with its key segment and first/last
// flags, buffering through a 2-entry skid buffer toward the host.
module dilithium_kg_unloader
   import dilithium_kg_unloader_pkg::*;
#(
   parameter int unsigned W         = 64,
   parameter logic        HIGH_PERF = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [2:0]   sec_lvl,
   input  logic         core_valid_i,
   output logic         core_ready_o,
   input  logic [W-1:0] core_data_i,
   output logic         m_valid_o,
   input  logic         m_ready_i,
   output logic [W-1:0] m_data_o,
   output logic [2:0]   m_seg_o,
   output logic         m_first_o,
   output logic         m_last_o,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o
);

   localparam int unsigned DW = W + 3 + 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_t;

   state_t               state;
   logic                 run_q;
   logic [2:0]           lvl_q;
   logic [SEG_IDX_W-1:0] seg_idx;
   logic [CNT_W-1:0]     word_cnt;

   seg_t                 cur_seg;
   logic [CNT_W-1:0]     cur_len;
   logic                 cur_first;
   logic                 cur_last;
   logic                 final_seg;
   logic                 accept;
   logic                 pop;

   logic                 buf_in_ready;
   logic [DW-1:0]        buf_in_data;
   logic [DW-1:0]        buf_out_data;
   logic [1:0]           buf_count;

   always_comb begin
      cur_seg     = seg_at(HIGH_PERF, seg_idx);
      cur_len     = seg_words(cur_seg, lvl_q, W);
      cur_first   = (word_cnt == '0);
      cur_last    = (word_cnt == cur_len - 10'd1);
      final_seg   = (seg_idx == last_seg_idx(HIGH_PERF));
      accept      = core_valid_i & core_ready_o;
      pop         = m_valid_o & m_ready_i;
      buf_in_data = {core_data_i, cur_seg, cur_first, cur_last};
   end

   // Both terms are registers, so core_ready_o never depends on m_ready_i combinationally.
   assign core_ready_o = run_q & buf_in_ready;

   assign m_data_o  = buf_out_data[DW-1:5];
   assign m_seg_o   = buf_out_data[4:2];
   assign m_first_o = buf_out_data[1];
   assign m_last_o  = buf_out_data[0];

   kg_skid_buf #(
      .DW(DW)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (core_valid_i & run_q),
      .in_ready (buf_in_ready),
      .in_data  (buf_in_data),
      .out_valid(m_valid_o),
      .out_ready(m_ready_i),
      .out_data (buf_out_data),
      .count    (buf_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         run_q    <= 1'b0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         err_o    <= 1'b0;
         lvl_q    <= '0;
         seg_idx  <= '0;
         word_cnt <= '0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (lvl_legal(sec_lvl)) begin
                     state    <= ST_RUN;
                     run_q    <= 1'b1;
                     busy_o   <= 1'b1;
                     lvl_q    <= sec_lvl;
                     seg_idx  <= '0;
                     word_cnt <= '0;
                  end else begin
                     err_o <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (accept) begin
                  if (cur_last) begin
                     word_cnt <= '0;
                     if (final_seg) begin
                        state <= ST_DRAIN;
                        run_q <= 1'b0;
                     end else begin
                        seg_idx <= seg_idx + 3'd1;
                     end
                  end else begin
                     word_cnt <= word_cnt + 10'd1;
                  end
               end
            end
            ST_DRAIN: begin
               // Nothing enters in DRAIN, so popping the last entry empties the buffer.
               if (pop && buf_count == 2'd1) begin
                  state  <= ST_IDLE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
